// File: rtl/pbkdf2_block_sequencer_if.sv
// pbkdf2_block_sequencer_if
// Bundles the sequencer's host-side handshake (start/header in; busy/done/
// error/dk out) and its HMAC-core-side bus (core_enable/core_data out;
// core_hash/core_hash_done in).
//   master : the sequencer's view (drives busy/done/error/dk/core_*)
//   slave  : the environment's view (header source plus HMAC core)
interface pbkdf2_block_sequencer_if #(
  parameter int NUM_BLOCKS = 4
);
  localparam int DK_W = 256 * NUM_BLOCKS;

  logic            start;
  logic [639:0]    header;
  logic            busy;
  logic            done;
  logic            error;
  logic [DK_W-1:0] dk;
  logic            core_enable;
  logic [1311:0]   core_data;
  logic [255:0]    core_hash;
  logic            core_hash_done;

  modport master (
    input  start, header, core_hash, core_hash_done,
    output busy, done, error, dk, core_enable, core_data
  );

  modport slave (
    output start, header, core_hash, core_hash_done,
    input  busy, done, error, dk, core_enable, core_data
  );
endinterface

// File: rtl/pbkdf2_block_sequencer.sv
// pbkdf2_block_sequencer
// Drives one shared HMAC-SHA256 core through NUM_BLOCKS jobs to form the
// PBKDF2-HMAC-SHA256 (c=1) derived key used by scrypt for one 80-byte header.
// Job i uses key = header and message = header || INT(i) (big-endian), and
// its hash lands in dk block i.
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   bus.start      request, honoured only while idle
//   bus.header     640-bit header, byte k at [8k +: 8], sampled on accept
//   bus.busy       high from the cycle after accept until done/error
//   bus.done       one-cycle pulse when dk is complete
//   bus.error      one-cycle pulse when a core job times out
//   bus.dk         derived key, block i at [256(i-1) +: 256]
//   bus.core_enable  one-cycle launch pulse to the core
//   bus.core_data    core input {INT(i), header, header}
//   bus.core_hash    core result
//   bus.core_hash_done core completion flag (a rising edge means done)
module pbkdf2_block_sequencer #(
  parameter int NUM_BLOCKS     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  pbkdf2_block_sequencer_if.master      bus
);

  localparam int DK_W = 256 * NUM_BLOCKS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              core_enable_q, core_enable_d;
  logic [DK_W-1:0]   dk_q, dk_d;
  logic [1311:0]     core_data_q, core_data_d;
  logic [3:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hd_prev_q, hd_prev_d;
  logic              hd_rise;

  // Core input word: key in [639:0], message header in [1279:640],
  // then INT(i) big-endian so the block index is the last byte.
  function automatic logic [1311:0] build_core_data(input logic [639:0] hdr,
                                                    input logic [3:0]   idx);
    return {4'h0, idx, 24'h00_0000, hdr, hdr};
  endfunction

  // Completion is only a fresh rising edge; a level held over from the
  // previous job must not count again.
  assign hd_rise = bus.core_hash_done & ~hd_prev_q;

  // Next-state and next-output computation for the job sequencer.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
    core_enable_d = 1'b0;
    dk_d          = dk_q;
    core_data_d   = core_data_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    hd_prev_d     = bus.core_hash_done;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Outputs are registered, so the launch pulse is scheduled on
          // entry to LAUNCH together with the first job's data.
          state_d       = S_LAUNCH;
          busy_d        = 1'b1;
          core_enable_d = 1'b1;
          idx_d         = 4'd1;
          dk_d          = '0;
          core_data_d   = build_core_data(bus.header, 4'd1);
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      S_LAUNCH: begin
        state_d = S_WAIT;
        busy_d  = 1'b1;
        cnt_d   = '0;
      end

      S_WAIT: begin
        busy_d = 1'b1;
        if (hd_rise) begin
          for (int b = 0; b < NUM_BLOCKS; b++) begin
            dk_d[b*256 +: 256] = (idx_q == 4'(b + 1)) ? bus.core_hash
                                                      : dk_q[b*256 +: 256];
          end
          if (idx_q == 4'(NUM_BLOCKS)) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            // The header is recovered from the key field of core_data.
            state_d       = S_LAUNCH;
            core_enable_d = 1'b1;
            idx_d         = idx_q + 4'd1;
            core_data_d   = build_core_data(core_data_q[639:0], idx_q + 4'd1);
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_FAIL;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      S_FAIL: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      core_enable_q <= 1'b0;
      dk_q          <= '0;
      core_data_q   <= '0;
      idx_q         <= 4'd1;
      cnt_q         <= '0;
      hd_prev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      core_enable_q <= core_enable_d;
      dk_q          <= dk_d;
      core_data_q   <= core_data_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      hd_prev_q     <= hd_prev_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.dk          = dk_q;
  assign bus.core_enable = core_enable_q;
  assign bus.core_data   = core_data_q;

endmodule
